// File: rtl/cnn_accel_pkg.sv
// ---------------------------------------------------------------------------
// cnn_accel_pkg
// Shared constants and helpers for the accumulator post-processing path:
// operand widths, the 30-bit internal sum width, the largest useful shift
// and the 16-bit saturation limits. There are no ports; the package is
// imported by postprocess_fifo and accumulator_postprocess.
// ---------------------------------------------------------------------------
package cnn_accel_pkg;

   localparam int ACC_BIT_WIDTH   = 28;
   localparam int BIAS_BIT_WIDTH  = 16;
   localparam int DATA_BIT_WIDTH  = 16;
   localparam int SHIFT_BIT_WIDTH = 5;
   localparam int FIFO_DEPTH      = 4;
   localparam int FIFO_ADDR_WIDTH = 2;

   // Two guard bits above the accumulator keep sum + bias + rounding
   // constant from wrapping.
   localparam int SUM_BIT_WIDTH   = 30;
   localparam int WORD_BIT_WIDTH  = 2 * DATA_BIT_WIDTH;

   // Shifting further than the accumulator width only yields sign bits.
   localparam logic [SHIFT_BIT_WIDTH-1:0] MAX_SHIFT = 5'd27;

   localparam logic [DATA_BIT_WIDTH-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [DATA_BIT_WIDTH-1:0] SAT_MIN = 16'h8000;

   typedef logic [DATA_BIT_WIDTH-1:0] elem_t;
   typedef logic [WORD_BIT_WIDTH-1:0] word_t;

   function automatic logic [SHIFT_BIT_WIDTH-1:0] clamp_shift(
      input logic [SHIFT_BIT_WIDTH-1:0] sh
   );
      return (sh > MAX_SHIFT) ? MAX_SHIFT : sh;
   endfunction

   // Clip a 30-bit signed value into the signed 16-bit element range.
   function automatic elem_t saturate(input logic signed [SUM_BIT_WIDTH-1:0] v);
      logic signed [SUM_BIT_WIDTH-1:0] hi;
      logic signed [SUM_BIT_WIDTH-1:0] lo;
      hi = $signed({{(SUM_BIT_WIDTH-DATA_BIT_WIDTH){1'b0}}, SAT_MAX});
      lo = $signed({{(SUM_BIT_WIDTH-DATA_BIT_WIDTH){1'b1}}, SAT_MIN});
      if (v > hi) begin
         return SAT_MAX;
      end else if (v < lo) begin
         return SAT_MIN;
      end
      return v[DATA_BIT_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/postprocess_fifo.sv
// ---------------------------------------------------------------------------
// postprocess_fifo
// Small synchronous FIFO of packed result words with an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is ignored (the caller flags the drop). dout shows the head
// word and reads as zero while the FIFO is empty.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   push      write din this cycle
//   pop       remove the head word this cycle (ignored when empty)
//   din       word to write
//   dout      head word, zero when empty
//   full      all entries occupied
//   empty     no entries occupied
// ---------------------------------------------------------------------------
module postprocess_fifo
   import cnn_accel_pkg::*;
#(
   parameter int WIDTH      = WORD_BIT_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;

   logic w_do_pop;
   logic w_do_push;

   assign full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));
   assign empty = (r_count == '0);

   assign w_do_pop  = pop && !empty;
   // When full, the slot under the read pointer frees up at this edge, so a
   // simultaneous push can reuse it without losing order.
   assign w_do_push = push && (!full || w_do_pop);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; only the pointers and count
   // are, and dout is gated by empty so stale contents never reach the port.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   assign dout = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/accumulator_postprocess.sv
// ---------------------------------------------------------------------------
// accumulator_postprocess
// Post-processes 28-bit signed convolution sums: bias add (stage 1),
// round-half-up arithmetic right shift, 16-bit saturation and optional ReLU
// (stage 2), then packs two elements per 32-bit word into a FIFO that
// drains over valid/ready. Upstream cannot stall, so a word arriving at a
// full FIFO with no pop is dropped and overflow_o latches until reset.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   result_valid_i  accumulator_i (and its side-band inputs) valid
//   accumulator_i   signed sum from the quad accumulator adder
//   last_i          final element of a channel; flushes an odd element
//   bias_i          signed bias, LSB-aligned with the accumulator
//   shift_i         right-shift amount, clamped to 27
//   relu_en_i       clamp negative results to zero
//   data_o          FIFO head word: element 0 in [15:0], element 1 in [31:16]
//   data_valid_o    FIFO not empty
//   data_ready_i    downstream accepts data_o
//   overflow_o      sticky: a word was dropped at a full FIFO
//   busy_o          pipeline, packer or FIFO holds data
// ---------------------------------------------------------------------------
module accumulator_postprocess
   import cnn_accel_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       result_valid_i,
   input  logic [ACC_BIT_WIDTH-1:0]   accumulator_i,
   input  logic                       last_i,
   input  logic [BIAS_BIT_WIDTH-1:0]  bias_i,
   input  logic [SHIFT_BIT_WIDTH-1:0] shift_i,
   input  logic                       relu_en_i,
   output logic [WORD_BIT_WIDTH-1:0]  data_o,
   output logic                       data_valid_o,
   input  logic                       data_ready_i,
   output logic                       overflow_o,
   output logic                       busy_o
);

   // ---------------- stage 1: bias add, shift clamp ----------------
   logic signed [SUM_BIT_WIDTH-1:0] w_s1_sum;

   logic                            r_s1_valid;
   logic signed [SUM_BIT_WIDTH-1:0] r_s1_sum;
   logic [SHIFT_BIT_WIDTH-1:0]      r_s1_shift;
   logic                            r_s1_relu;
   logic                            r_s1_last;

   assign w_s1_sum =
      $signed({{(SUM_BIT_WIDTH-ACC_BIT_WIDTH){accumulator_i[ACC_BIT_WIDTH-1]}}, accumulator_i}) +
      $signed({{(SUM_BIT_WIDTH-BIAS_BIT_WIDTH){bias_i[BIAS_BIT_WIDTH-1]}}, bias_i});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
         r_s1_shift <= '0;
         r_s1_relu  <= 1'b0;
         r_s1_last  <= 1'b0;
      end else begin
         r_s1_valid <= result_valid_i;
         if (result_valid_i) begin
            r_s1_sum   <= w_s1_sum;
            r_s1_shift <= clamp_shift(shift_i);
            r_s1_relu  <= relu_en_i;
            r_s1_last  <= last_i;
         end
      end
   end

   // ---------------- stage 2: round, shift, saturate, ReLU ----------------
   logic signed [SUM_BIT_WIDTH-1:0] w_round;
   logic signed [SUM_BIT_WIDTH-1:0] w_pre_shift;
   logic signed [SUM_BIT_WIDTH-1:0] w_shifted;
   elem_t                           w_sat;
   elem_t                           w_s2_data;

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_round = '0;
      if (r_s1_shift != '0) begin
         w_round = SUM_BIT_WIDTH'(1) << (r_s1_shift - SHIFT_BIT_WIDTH'(1));
      end
      // Adding half an LSB before an arithmetic (floor) shift rounds ties
      // toward +inf for both signs.
      w_pre_shift = r_s1_sum + w_round;
      w_shifted   = w_pre_shift >>> r_s1_shift;
      w_sat       = saturate(w_shifted);
      w_s2_data   = (r_s1_relu && w_sat[DATA_BIT_WIDTH-1]) ? '0 : w_sat;
   end

   logic  r_s2_valid;
   elem_t r_s2_data;
   logic  r_s2_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_last  <= 1'b0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data <= w_s2_data;
            r_s2_last <= r_s1_last;
         end
      end
   end

   // ---------------- packer ----------------
   logic  r_pack_half;
   elem_t r_pack_low;
   logic  w_push;
   word_t w_push_word;

   // A word completes when a low half is already held, or when a lone
   // element is marked last and must be flushed with a zero high half.
   assign w_push      = r_s2_valid && (r_pack_half || r_s2_last);
   assign w_push_word = r_pack_half ? {r_s2_data, r_pack_low}
                                    : {{DATA_BIT_WIDTH{1'b0}}, r_s2_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pack_half <= 1'b0;
         r_pack_low  <= '0;
      end else if (r_s2_valid) begin
         if (r_pack_half || r_s2_last) begin
            r_pack_half <= 1'b0;
         end else begin
            r_pack_half <= 1'b1;
            r_pack_low  <= r_s2_data;
         end
      end
   end

   // ---------------- output FIFO and overrun flag ----------------
   logic w_full;
   logic w_empty;
   logic w_pop;
   logic r_overflow;

   assign w_pop = !w_empty && data_ready_i;

   postprocess_fifo #(
      .WIDTH      (WORD_BIT_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_push_word),
      .dout  (data_o),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   assign data_valid_o = !w_empty;
   assign overflow_o   = r_overflow;
   assign busy_o       = r_s1_valid || r_s2_valid || r_pack_half || !w_empty;

endmodule

// File: tb/tb_accumulator_postprocess.sv
// ---------------------------------------------------------------------------
// tb_accumulator_postprocess
// Directed bench for accumulator_postprocess. Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle away from
// the active rising edge. Expected words are hand-computed from the
// arithmetic definition: ((acc + bias + half LSB) >>> shift), saturated,
// ReLU, packed low element first.
// ---------------------------------------------------------------------------
module tb_accumulator_postprocess;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        result_valid_i = 1'b0;
   logic [27:0] accumulator_i = '0;
   logic        last_i = 1'b0;
   logic [15:0] bias_i = '0;
   logic [4:0]  shift_i = '0;
   logic        relu_en_i = 1'b0;
   logic [31:0] data_o;
   logic        data_valid_o;
   logic        data_ready_i = 1'b0;
   logic        overflow_o;
   logic        busy_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   accumulator_postprocess dut (
      .clk            (clk),
      .rst            (rst),
      .result_valid_i (result_valid_i),
      .accumulator_i  (accumulator_i),
      .last_i         (last_i),
      .bias_i         (bias_i),
      .shift_i        (shift_i),
      .relu_en_i      (relu_en_i),
      .data_o         (data_o),
      .data_valid_o   (data_valid_o),
      .data_ready_i   (data_ready_i),
      .overflow_o     (overflow_o),
      .busy_o         (busy_o)
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
   endtask

   // Present one element for one cycle (valid stays high until idle()).
   task automatic send(input logic [27:0] acc, input logic [15:0] bias,
                       input logic [4:0] sh, input logic relu, input logic last);
      @(negedge clk);
      result_valid_i = 1'b1;
      accumulator_i  = acc;
      bias_i         = bias;
      shift_i        = sh;
      relu_en_i      = relu;
      last_i         = last;
   endtask

   task automatic idle();
      @(negedge clk);
      result_valid_i = 1'b0;
      last_i         = 1'b0;
   endtask

   // Wait (bounded) for a head word, compare it, then pop it with a
   // one-cycle ready pulse.
   task automatic expect_word(input string name, input logic [31:0] exp);
      for (int i = 0; i < 20 && !data_valid_o; i++) @(negedge clk);
      check({name, " valid"}, {31'd0, data_valid_o}, 32'd1);
      check({name, " data"}, data_o, exp);
      data_ready_i = 1'b1;
      @(negedge clk);
      data_ready_i = 1'b0;
   endtask

   initial begin
      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      check("rst data_o", data_o, 32'h0);
      check("rst data_valid", {31'd0, data_valid_o}, 32'd0);
      check("rst overflow", {31'd0, overflow_o}, 32'd0);
      check("rst busy", {31'd0, busy_o}, 32'd0);
      rst = 1'b0;

      // ---------------- rounding, packing, latency ----------------
      data_ready_i = 1'b1;
      send(28'd1000, 16'd24, 5'd4, 1'b0, 1'b0);   // (1024+8)>>>4 = 64
      send(-28'sd48, 16'd0, 5'd4, 1'b0, 1'b0);    // (-48+8)>>>4 = -3
      idle();
      check("lat edge1 valid", {31'd0, data_valid_o}, 32'd0);
      @(negedge clk);
      check("lat edge2 valid", {31'd0, data_valid_o}, 32'd0);
      @(negedge clk);
      check("lat edge3 valid", {31'd0, data_valid_o}, 32'd1);
      check("pack word", data_o, 32'hFFFD0040);
      @(negedge clk);
      check("pack popped", {31'd0, data_valid_o}, 32'd0);
      data_ready_i = 1'b0;

      // ---------------- saturation and ReLU ----------------
      send(28'h0FFFFFF, 16'd0, 5'd0, 1'b0, 1'b0); // -> 7FFF
      send(-28'sd5,     16'd0, 5'd0, 1'b1, 1'b0); // relu -> 0000
      send(28'h8000000, 16'd0, 5'd0, 1'b0, 1'b0); // -> 8000
      send(-28'sd5,     16'd0, 5'd0, 1'b0, 1'b0); // no relu -> FFFB
      idle();
      expect_word("sat hi relu", 32'h00007FFF);
      expect_word("sat lo", 32'hFFFB8000);

      // ---------------- ties round toward +inf ----------------
      send(28'd24,   16'd0, 5'd4, 1'b0, 1'b0);    // 1.5 -> 2
      send(-28'sd40, 16'd0, 5'd4, 1'b0, 1'b0);    // -2.5 -> -2
      idle();
      expect_word("round ties", 32'hFFFE0002);

      // ---------------- negative bias, shift clamp, last into high half --
      send(28'd100, -16'sd36, 5'd2, 1'b0, 1'b0);  // (64+2)>>>2 = 16
      send(28'h4000000, 16'd0, 5'd31, 1'b0, 1'b1); // clamped to 27 -> 1
      idle();
      expect_word("bias clamp", 32'h00010010);

      // ---------------- last flush of a single element ----------------
      send(28'd32, 16'd0, 5'd1, 1'b0, 1'b1);      // (32+1)>>>1 = 16
      idle();
      expect_word("last flush", 32'h00000010);
      check("last busy after pop", {31'd0, busy_o}, 32'd0);

      // ---------------- full FIFO with simultaneous push and pop --------
      for (int k = 1; k <= 8; k++) send(28'(k), 16'd0, 5'd0, 1'b0, 1'b0);
      idle();
      repeat (4) @(negedge clk);
      check("fill valid", {31'd0, data_valid_o}, 32'd1);
      send(28'd9,  16'd0, 5'd0, 1'b0, 1'b0);
      send(28'd10, 16'd0, 5'd0, 1'b0, 1'b0);
      idle();
      @(negedge clk);
      data_ready_i = 1'b1;                         // pop coincides with push
      @(negedge clk);
      data_ready_i = 1'b0;
      check("pp overflow", {31'd0, overflow_o}, 32'd0);
      expect_word("pp w2", 32'h00040003);
      expect_word("pp w3", 32'h00060005);
      expect_word("pp w4", 32'h00080007);
      expect_word("pp w5", 32'h000A0009);
      @(negedge clk);
      check("pp drained", {31'd0, data_valid_o}, 32'd0);

      // ---------------- reset mid-operation ----------------
      for (int k = 1; k <= 5; k++) send(28'(k), 16'd0, 5'd0, 1'b0, 1'b0);
      idle();
      repeat (3) @(negedge clk);
      check("mid busy", {31'd0, busy_o}, 32'd1);
      check("mid valid", {31'd0, data_valid_o}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid rst data_o", data_o, 32'h0);
      check("mid rst valid", {31'd0, data_valid_o}, 32'd0);
      check("mid rst overflow", {31'd0, overflow_o}, 32'd0);
      check("mid rst busy", {31'd0, busy_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(28'd100, 16'd0, 5'd0, 1'b0, 1'b0);
      send(28'd200, 16'd0, 5'd0, 1'b0, 1'b0);
      idle();
      expect_word("post rst pair", 32'h00C80064);
      check("post rst busy", {31'd0, busy_o}, 32'd0);

      // ---------------- overflow ----------------
      for (int k = 1; k <= 10; k++) send(28'(k), 16'd0, 5'd0, 1'b0, 1'b0);
      idle();
      repeat (4) @(negedge clk);
      check("ovf flag", {31'd0, overflow_o}, 32'd1);
      expect_word("ovf w1", 32'h00020001);
      expect_word("ovf w2", 32'h00040003);
      expect_word("ovf w3", 32'h00060005);
      expect_word("ovf w4", 32'h00080007);
      data_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      data_ready_i = 1'b0;
      check("ovf only 4 words", {31'd0, data_valid_o}, 32'd0);
      check("ovf sticky", {31'd0, overflow_o}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/accumulator_postprocess.md
Name: accumulator_postprocess

Overview:
- Sits directly downstream of the quad accumulator adder and consumes its 28-bit signed convolution sums.
- Each sum passes through a two-stage pipeline: bias add, rounding arithmetic right shift, saturation to 16 bits and optional ReLU.
- Results are packed two per 32-bit word into a small FIFO that drains to the output buffer over a valid/ready handshake.
- Upstream cannot stall, so FIFO overrun drops the word and raises a sticky flag.

Parameters:
- ACC_BIT_WIDTH, 28: input sum width, signed two's complement.
- BIAS_BIT_WIDTH, 16: bias width, signed, aligned to the accumulator LSB.
- DATA_BIT_WIDTH, 16: output element width, signed.
- SHIFT_BIT_WIDTH, 5: right-shift amount width.
- FIFO_DEPTH, 4: number of packed-word FIFO entries.
- FIFO_ADDR_WIDTH, 2: log2(FIFO_DEPTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- result_valid_i  input  1  accumulator_i is valid this cycle.
- accumulator_i  input  ACC_BIT_WIDTH  signed sum from the quad accumulator adder.
- last_i  input  1  qualifies the final element of a channel; with result_valid_i it forces a flush of an odd element.
- bias_i  input  BIAS_BIT_WIDTH  signed bias, sampled with result_valid_i.
- shift_i  input  SHIFT_BIT_WIDTH  right-shift amount, sampled with result_valid_i.
- relu_en_i  input  1  ReLU enable, sampled with result_valid_i.
- data_o  output  2*DATA_BIT_WIDTH  FIFO head word; element 0 in [15:0], element 1 in [31:16].
- data_valid_o  output  1  FIFO not empty.
- data_ready_i  input  1  downstream accepts data_o.
- overflow_o  output  1  sticky; a word was dropped because the FIFO was full.
- busy_o  output  1  any pipeline stage valid, packer holds a half word, or FIFO not empty.

Behaviour:
- Reset (async, immediate) clears:
  - all stage valid bits, packer half-word flag, FIFO pointers and count;
  - outputs: data_valid_o=0, data_o=0, overflow_o=0, busy_o=0.
  - An in-flight element is discarded, with no partial-word flush.
- Stage 1 (edge N+1 after a valid at cycle N):
  - sum = sext(accumulator_i, 30) + sext(bias_i, 30).
  - shift_i is clamped to 27 if larger; shift_i, relu_en_i and last_i are registered alongside the sum.
- Stage 2 (edge N+2):
  - r = (sum + (sh>0 ? 1<<(sh-1) : 0)) >>> sh, computed in 30 bits. This is round half up, toward +inf.
  - Saturate r to [-32768, 32767].
  - If relu is set and the result is negative, the result is 0.
- Packer (edge N+3):
  - Packer empty and element not last: the element is held as the low half.
  - Packer holds a low half: the new element goes to the high half, and the word is pushed.
  - Packer empty and element last: push {16'h0000, element}.
  - The packer is then empty again.
- Latency: data_valid_o rises 3 cycles after the valid that completes a word, when the FIFO was empty.
- FIFO behaviour:
  - Pop occurs when data_valid_o && data_ready_i.
  - If push and pop happen in the same cycle while full, both proceed, the count is unchanged and no overflow is flagged.
  - If push happens while full with no pop, the word is dropped and overflow_o is set. It stays set until reset.
  - data_o must be stable while data_valid_o=1 and data_ready_i=0.
- Back-to-back valids every cycle are supported at full throughput: one element per cycle and one word per two cycles.
- bias_i, shift_i and relu_en_i may change every valid cycle; each element uses the values sampled with it.

Decomposition:
- Shared package (cnn_accel_pkg) holds the constants ACC_BIT_WIDTH, DATA_BIT_WIDTH, SHIFT_BIT_WIDTH and the saturation limits SAT_MAX=16'h7FFF / SAT_MIN=16'h8000.
- One sub-module, postprocess_fifo:
  - synchronous FIFO with a count, async active-high reset;
  - ports push, pop, din, dout, full, empty.
- The arithmetic pipeline and packer stay in the top module.

Test Plan:
- Rounding and packing: (acc=1000, bias=24, shift=4, relu=0), then (acc=-48, bias=0, shift=4, relu=0) on consecutive cycles, ready=1 -> one word 32'hFFFD0040, data_valid_o rises 3 cycles after the second valid.
- Saturation and ReLU:
  - acc=28'h0FFFFFF, bias=0, shift=0 -> element 16'h7FFF.
  - acc=-28'd5 with relu=1 -> element 16'h0000.
  - acc=28'h8000000, shift=0, relu=0 -> element 16'h8000.
- Last flush: a single valid with last_i=1, acc=32, bias=0, shift=1 -> word 32'h00000010; busy_o drops after the pop.
- Overflow: data_ready_i=0, 10 back-to-back valids -> 4 words stored in order, 5th dropped, overflow_o=1. Then ready=1 -> exactly 4 words are drained, and overflow_o stays 1.
- Full with simultaneous push/pop: FIFO full, ready=1 in the same cycle as a push -> no drop, overflow_o=0, FIFO order preserved.
- Reset mid-operation: assert rst while the packer holds a half word and the FIFO has 2 entries -> all outputs are 0 immediately. The next pair after reset produces a correctly packed word, with no stale half.
